// File: rtl/stack_pkg.sv
// ============================================================================
// Module      : stack_pkg
// Description : Shared types and reset defaults for the 8051 stack controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package stack_pkg;

    localparam logic [7:0] SP_SFR_ADDR_DEF = 8'h81;
    localparam logic [7:0] SP_INIT_DEF     = 8'h07;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PUSH_LO = 3'd1,
        ST_PUSH_HI = 3'd2,
        ST_POP_HI  = 3'd3,
        ST_POP_LO  = 3'd4,
        ST_POP_CAP = 3'd5,
        ST_FIN     = 3'd6
    } stack_state_e;

    typedef enum logic {
        W8  = 1'b0,
        W16 = 1'b1
    } xfer_w_e;

endpackage

`default_nettype wire

// File: rtl/stack_ctrl.sv
// ============================================================================
// Module      : stack_ctrl
// Description : Sequenced 8/16-bit push/pop engine driving IRAM, with SP SFR.
//               Define STACK_LIMIT_CHECK_EN to reject overflow/underflow.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stack_ctrl
    import stack_pkg::*;
#(
    parameter int                DATA_W      = 8,
    parameter int                ADDR_W      = 8,
    parameter logic [ADDR_W-1:0] SP_INIT     = ADDR_W'(SP_INIT_DEF),
    parameter logic [ADDR_W-1:0] SP_MAX      = {ADDR_W{1'b1}},
    parameter logic [7:0]        SP_SFR_ADDR = SP_SFR_ADDR_DEF
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                push,
    input  logic                pop,
    input  logic                wide,
    input  logic [2*DATA_W-1:0] data_in,
    output logic [2*DATA_W-1:0] data_out,
    input  logic [7:0]          sfr_addr,
    input  logic                sfr_wr,
    input  logic [DATA_W-1:0]   sfr_wdata,
    output logic [DATA_W-1:0]   sfr_rdata,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic [DATA_W-1:0]   ram_wdata,
    output logic                ram_we,
    output logic                ram_re,
    input  logic [DATA_W-1:0]   ram_rdata,
    output logic [ADDR_W-1:0]   sp_out,
    output logic                busy,
    output logic                done,
    output logic                fault
);

`ifdef STACK_LIMIT_CHECK_EN
    localparam bit LIMIT_EN = 1'b1;
`else
    localparam bit LIMIT_EN = 1'b0;
`endif

    localparam logic [ADDR_W:0] ONE_X = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0] TWO_X = (ADDR_W+1)'(2);
    localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

    stack_state_e        state_q, state_d;
    xfer_w_e             width_q, width_d;
    logic [ADDR_W-1:0]   sp_q, sp_d;
    logic [DATA_W-1:0]   hi_q, hi_d;
    logic [DATA_W-1:0]   cap_q, cap_d;
    logic [2*DATA_W-1:0] data_out_q, data_out_d;
    logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;
    logic                ram_we_q, ram_we_d;
    logic                ram_re_q, ram_re_d;
    logic                fault_q, fault_d;

    logic                w_sfr_hit;
    logic [ADDR_W:0]     w_sp_ext;
    logic                w_push_reject;
    logic                w_pop_reject;

    assign w_sfr_hit = sfr_wr && (sfr_addr == SP_SFR_ADDR);
    assign w_sp_ext  = {1'b0, sp_q};

    // Widened compare so a push from SP_MAX cannot wrap past the limit unseen.
    assign w_push_reject = LIMIT_EN &&
        ((wide ? (w_sp_ext + TWO_X) : (w_sp_ext + ONE_X)) > {1'b0, SP_MAX});
    assign w_pop_reject  = LIMIT_EN &&
        (wide ? (w_sp_ext < ({1'b0, SP_INIT} + TWO_X)) : (sp_q == SP_INIT));

    always_comb begin
        state_d     = state_q;
        width_d     = width_q;
        sp_d        = sp_q;
        hi_d        = hi_q;
        cap_d       = cap_q;
        data_out_d  = data_out_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        ram_we_d    = 1'b0;
        ram_re_d    = 1'b0;
        fault_d     = fault_q;

        case (state_q)
            ST_IDLE: begin
                if (w_sfr_hit) begin
                    sp_d    = ADDR_W'(sfr_wdata);
                    fault_d = 1'b0;
                end else if (push) begin
                    width_d = wide ? W16 : W8;
                    hi_d    = data_in[2*DATA_W-1:DATA_W];
                    if (w_push_reject) begin
                        fault_d = 1'b1;
                        state_d = ST_FIN;
                    end else begin
                        sp_d        = sp_q + ONE;
                        ram_addr_d  = sp_q + ONE;
                        ram_wdata_d = data_in[DATA_W-1:0];
                        ram_we_d    = 1'b1;
                        state_d     = ST_PUSH_LO;
                    end
                end else if (pop) begin
                    width_d = wide ? W16 : W8;
                    if (w_pop_reject) begin
                        fault_d = 1'b1;
                        state_d = ST_FIN;
                    end else begin
                        ram_addr_d = sp_q;
                        ram_re_d   = 1'b1;
                        sp_d       = sp_q - ONE;
                        state_d    = ST_POP_HI;
                    end
                end
            end
            ST_PUSH_LO: begin
                if (width_q == W16) begin
                    sp_d        = sp_q + ONE;
                    ram_addr_d  = sp_q + ONE;
                    ram_wdata_d = hi_q;
                    ram_we_d    = 1'b1;
                    state_d     = ST_PUSH_HI;
                end else begin
                    state_d = ST_FIN;
                end
            end
            ST_PUSH_HI: state_d = ST_FIN;
            ST_POP_HI: begin
                if (width_q == W16) begin
                    ram_addr_d = sp_q;
                    ram_re_d   = 1'b1;
                    sp_d       = sp_q - ONE;
                    state_d    = ST_POP_LO;
                end else begin
                    state_d = ST_POP_CAP;
                end
            end
            ST_POP_LO: begin
                cap_d   = ram_rdata;
                state_d = ST_POP_CAP;
            end
            ST_POP_CAP: begin
                // data_out only changes here so the previous result stays intact mid-pop.
                data_out_d = (width_q == W16) ? {cap_q, ram_rdata}
                                              : {{DATA_W{1'b0}}, ram_rdata};
                state_d    = ST_FIN;
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            width_q     <= W8;
            sp_q        <= SP_INIT;
            hi_q        <= '0;
            cap_q       <= '0;
            data_out_q  <= '0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            ram_we_q    <= 1'b0;
            ram_re_q    <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            width_q     <= width_d;
            sp_q        <= sp_d;
            hi_q        <= hi_d;
            cap_q       <= cap_d;
            data_out_q  <= data_out_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            ram_we_q    <= ram_we_d;
            ram_re_q    <= ram_re_d;
            fault_q     <= fault_d;
        end
    end

    assign data_out  = data_out_q;
    assign sfr_rdata = (sfr_addr == SP_SFR_ADDR) ? DATA_W'(sp_q) : '0;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign ram_we    = ram_we_q;
    assign ram_re    = ram_re_q;
    assign sp_out    = sp_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_FIN);
    assign fault     = fault_q;

endmodule

`default_nettype wire
